// File: rtl/util_pkg.sv
// Shared ROB defaults and the per-entry record used by rob_nway.
package util_pkg;

  localparam int ROB_DEPTH    = 8;
  localparam int ROB_ALLOC_W  = 2;
  localparam int ROB_COMMIT_W = 2;
  localparam int ROB_L_ADDR_W = 6;
  localparam int ROB_P_ADDR_W = 6;

  typedef struct packed {
    logic                    valid;
    logic                    pending;
    logic                    flushed;
    logic                    valid_dest;
    logic                    exception;
    logic [3:0]              cause;
    logic [ROB_L_ADDR_W-1:0] lreg;
    logic [ROB_P_ADDR_W-1:0] preg;
    logic [ROB_P_ADDR_W-1:0] ppreg;
    logic [31:0]             pc;
  } rob_nway_entry_t;

endpackage

// File: rtl/rob_commit_sel.sv
// Picks which head-relative lanes retire this cycle; an unflushed exception
// may only retire alone in lane 0 and blocks everything behind it.
module rob_commit_sel #(
  parameter int COMMIT_W = 2,
  parameter int CNT_W    = 4
) (
  input  logic [COMMIT_W-1:0] valid,
  input  logic [COMMIT_W-1:0] pending,
  input  logic [COMMIT_W-1:0] flushed,
  input  logic [COMMIT_W-1:0] exception,
  output logic [COMMIT_W-1:0] lanes,
  output logic [CNT_W-1:0]    ncommit
);

  logic chain_ok;
  logic exc_live;

  always_comb begin
    lanes    = '0;
    ncommit  = '0;
    chain_ok = 1'b1;
    exc_live = 1'b0;
    for (int i = 0; i < COMMIT_W; i++) begin
      exc_live = exception[i] & ~flushed[i];
      if (chain_ok && valid[i] && (!pending[i] || flushed[i]) && !((i != 0) && exc_live)) begin
        lanes[i] = 1'b1;
        ncommit  = ncommit + CNT_W'(1);
        if (exc_live) chain_ok = 1'b0;
      end else begin
        chain_ok = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rob_nway.sv
// N-wide reorder buffer: multi-lane allocate, multi-port writeback,
// branch-miss flush of younger entries and in-order multi-lane commit.
module rob_nway
  import util_pkg::*;
#(
  parameter int DEPTH    = ROB_DEPTH,
  parameter int ALLOC_W  = ROB_ALLOC_W,
  parameter int COMMIT_W = ROB_COMMIT_W,
  parameter int WB_PORTS = 2,
  parameter int P_ADDR_W = ROB_P_ADDR_W,
  parameter int L_ADDR_W = ROB_L_ADDR_W,
  parameter int IDX_W    = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [ALLOC_W-1:0]           alloc_valid,
  input  logic [ALLOC_W-1:0]           alloc_valid_dest,
  input  logic [ALLOC_W*L_ADDR_W-1:0]  alloc_lreg,
  input  logic [ALLOC_W*P_ADDR_W-1:0]  alloc_preg,
  input  logic [ALLOC_W*P_ADDR_W-1:0]  alloc_ppreg,
  input  logic [ALLOC_W*32-1:0]        alloc_pc,
  output logic                         alloc_ready,
  output logic [ALLOC_W*IDX_W-1:0]     alloc_ticket,
  output logic [IDX_W:0]               free_count,
  output logic                         is_full,
  output logic                         two_empty,
  input  logic [WB_PORTS-1:0]          wb_valid,
  input  logic [WB_PORTS*IDX_W-1:0]    wb_ticket,
  input  logic [WB_PORTS-1:0]          wb_exception,
  input  logic [WB_PORTS*4-1:0]        wb_cause,
  input  logic                         flush_valid,
  input  logic [IDX_W-1:0]             flush_ticket,
  input  logic                         commit_ready,
  output logic [COMMIT_W-1:0]          commit_valid,
  output logic [COMMIT_W-1:0]          commit_flushed,
  output logic [COMMIT_W-1:0]          commit_valid_dest,
  output logic [COMMIT_W*L_ADDR_W-1:0] commit_lreg,
  output logic [COMMIT_W*P_ADDR_W-1:0] commit_preg,
  output logic [COMMIT_W*P_ADDR_W-1:0] commit_ppreg,
  output logic [COMMIT_W*IDX_W-1:0]    commit_ticket,
  output logic                         exc_valid,
  output logic [3:0]                   exc_cause,
  output logic [31:0]                  exc_pc
);

  localparam int CNT_W = IDX_W + 1;

  rob_nway_entry_t entries [DEPTH];
  rob_nway_entry_t alloc_entry [ALLOC_W];

  logic [IDX_W-1:0]    head;
  logic [IDX_W-1:0]    tail;
  logic [CNT_W-1:0]    count;
  logic [CNT_W-1:0]    nalloc;
  logic [IDX_W-1:0]    next_ticket;
  logic [COMMIT_W-1:0] rot_valid;
  logic [COMMIT_W-1:0] rot_pending;
  logic [COMMIT_W-1:0] rot_flushed;
  logic [COMMIT_W-1:0] rot_exception;
  logic [COMMIT_W-1:0] lanes;
  logic [CNT_W-1:0]    ncommit;
  logic [DEPTH-1:0]    flush_mask;
  logic [IDX_W-1:0]    flush_dist;
  logic [IDX_W-1:0]    entry_dist;
  logic                exc_commit;

  assign free_count  = CNT_W'(DEPTH) - count;
  assign is_full     = (count == CNT_W'(DEPTH));
  assign two_empty   = (free_count >= CNT_W'(2));
  assign alloc_ready = !flush_valid && !exc_valid && (nalloc <= free_count);

  // Tickets are handed out densely: invalid lanes do not consume a slot.
  always_comb begin
    nalloc      = '0;
    next_ticket = tail;
    for (int i = 0; i < ALLOC_W; i++) begin
      alloc_ticket[i*IDX_W +: IDX_W] = next_ticket;
      if (alloc_valid[i]) begin
        next_ticket = next_ticket + IDX_W'(1);
        nalloc      = nalloc + CNT_W'(1);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < ALLOC_W; i++) begin
      alloc_entry[i] = '{valid:      1'b1,
                         pending:    1'b1,
                         flushed:    1'b0,
                         valid_dest: alloc_valid_dest[i],
                         exception:  1'b0,
                         cause:      4'h0,
                         lreg:       alloc_lreg[i*L_ADDR_W +: L_ADDR_W],
                         preg:       alloc_preg[i*P_ADDR_W +: P_ADDR_W],
                         ppreg:      alloc_ppreg[i*P_ADDR_W +: P_ADDR_W],
                         pc:         alloc_pc[i*32 +: 32]};
    end
  end

  for (genvar g = 0; g < COMMIT_W; g++) begin : g_head
    assign rot_valid[g]     = entries[head + IDX_W'(g)].valid;
    assign rot_pending[g]   = entries[head + IDX_W'(g)].pending;
    assign rot_flushed[g]   = entries[head + IDX_W'(g)].flushed;
    assign rot_exception[g] = entries[head + IDX_W'(g)].exception;
    assign commit_valid_dest[g]                 = entries[head + IDX_W'(g)].valid_dest;
    assign commit_lreg[g*L_ADDR_W +: L_ADDR_W]  = entries[head + IDX_W'(g)].lreg;
    assign commit_preg[g*P_ADDR_W +: P_ADDR_W]  = entries[head + IDX_W'(g)].preg;
    assign commit_ppreg[g*P_ADDR_W +: P_ADDR_W] = entries[head + IDX_W'(g)].ppreg;
    assign commit_ticket[g*IDX_W +: IDX_W]      = head + IDX_W'(g);
  end

  rob_commit_sel #(
    .COMMIT_W (COMMIT_W),
    .CNT_W    (CNT_W)
  ) u_commit_sel (
    .valid     (rot_valid),
    .pending   (rot_pending),
    .flushed   (rot_flushed),
    .exception (rot_exception),
    .lanes     (lanes),
    .ncommit   (ncommit)
  );

  assign commit_valid   = lanes;
  assign commit_flushed = lanes & rot_flushed;
  assign exc_commit     = commit_ready & lanes[0] & rot_exception[0] & ~rot_flushed[0];

  // Age is measured as distance from head so the comparison survives wrap.
  always_comb begin
    flush_mask = '0;
    flush_dist = flush_ticket - head;
    entry_dist = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_dist    = IDX_W'(i) - head;
      flush_mask[i] = flush_valid & entries[i].valid & (entry_dist > flush_dist);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      exc_valid <= 1'b0;
      exc_cause <= 4'h0;
      exc_pc    <= 32'h0;
    end else if (exc_commit) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i].valid     <= 1'b0;
        entries[i].pending   <= 1'b0;
        entries[i].flushed   <= 1'b0;
        entries[i].exception <= 1'b0;
      end
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      exc_valid <= 1'b1;
      exc_cause <= entries[head].cause;
      exc_pc    <= entries[head].pc;
    end else begin
      exc_valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        if (flush_mask[i]) entries[i].flushed <= 1'b1;
      end
      for (int p = 0; p < WB_PORTS; p++) begin
        if (wb_valid[p] && entries[wb_ticket[p*IDX_W +: IDX_W]].valid &&
            !entries[wb_ticket[p*IDX_W +: IDX_W]].flushed &&
            entries[wb_ticket[p*IDX_W +: IDX_W]].pending) begin
          entries[wb_ticket[p*IDX_W +: IDX_W]].pending   <= 1'b0;
          entries[wb_ticket[p*IDX_W +: IDX_W]].exception <= wb_exception[p];
          entries[wb_ticket[p*IDX_W +: IDX_W]].cause     <= wb_cause[p*4 +: 4];
        end
      end
      if (commit_ready) begin
        for (int i = 0; i < COMMIT_W; i++) begin
          if (lanes[i]) entries[head + IDX_W'(i)].valid <= 1'b0;
        end
      end
      if (alloc_ready) begin
        for (int i = 0; i < ALLOC_W; i++) begin
          if (alloc_valid[i]) entries[alloc_ticket[i*IDX_W +: IDX_W]] <= alloc_entry[i];
        end
      end
      head  <= head + (commit_ready ? ncommit[IDX_W-1:0] : '0);
      tail  <= tail + (alloc_ready ? nalloc[IDX_W-1:0] : '0);
      count <= count + (alloc_ready ? nalloc : '0) - (commit_ready ? ncommit : '0);
    end
  end

endmodule
